// File: rtl/tsb_bus_arbiter_if.sv
// Shared-bus handshake between the arbiter and its four requesters.
// master is the arbiter side, slave is the requester side.
interface tsb_bus_arbiter_if;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [3:0] en;
   logic [1:0] sel;
   logic       busy;

   modport master (input req, output gnt, en, sel, busy);
   modport slave  (output req, input gnt, en, sel, busy);
endinterface

// File: rtl/tsb_bus_arbiter.sv
// Four-way round-robin tristate bus arbiter.
// Grants are bounded by HOLD_MAX and separated by GAP cycles with all drivers off.
module tsb_bus_arbiter #(
   parameter int HOLD_MAX = 8,
   parameter int GAP      = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   tsb_bus_arbiter_if.master bus
);
   localparam int CW = $clog2(HOLD_MAX + 1);
   localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_MAX);
   localparam logic [3:0]    GAP_LIM  = 4'(GAP);

   typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

   state_t        state;
   logic [1:0]    ptr;
   logic [1:0]    sel_q;
   logic [3:0]    gnt_q;
   logic          busy_q;
   logic [CW-1:0] hold_cnt;
   logic [3:0]    gap_cnt;

   logic [3:0] rq;
   logic [1:0] win;
   logic       any;

   // Anything other than a clean 1 (X, Z, 0) counts as not requesting.
   always_comb begin
      rq = '0;
      for (int i = 0; i < 4; i++) rq[i] = (bus.req[i] === 1'b1);
   end

   // Scan from ptr+3 down to ptr so the lowest offset from ptr wins.
   always_comb begin
      any = |rq;
      win = ptr;
      for (int k = 3; k >= 0; k--)
         if (rq[ptr + 2'(k)]) win = ptr + 2'(k);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr      <= '0;
         sel_q    <= '0;
         gnt_q    <= '0;
         busy_q   <= 1'b0;
         hold_cnt <= '0;
         gap_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any) begin
                  state    <= GRANT;
                  gnt_q    <= 4'b0001 << win;
                  sel_q    <= win;
                  busy_q   <= 1'b1;
                  hold_cnt <= CW'(1);
               end
            end
            GRANT: begin
               // sel_q is the holder index while granted.
               if (!rq[sel_q] || hold_cnt == HOLD_LIM) begin
                  state    <= TURN;
                  ptr      <= sel_q + 2'd1;
                  gnt_q    <= '0;
                  sel_q    <= '0;
                  hold_cnt <= '0;
                  gap_cnt  <= 4'd1;
               end else begin
                  hold_cnt <= hold_cnt + CW'(1);
               end
            end
            TURN: begin
               if (gap_cnt == GAP_LIM) begin
                  gap_cnt <= '0;
                  if (any) begin
                     state    <= GRANT;
                     gnt_q    <= 4'b0001 << win;
                     sel_q    <= win;
                     hold_cnt <= CW'(1);
                  end else begin
                     state  <= IDLE;
                     busy_q <= 1'b0;
                  end
               end else begin
                  gap_cnt <= gap_cnt + 4'd1;
               end
            end
            default: begin
               state  <= IDLE;
               gnt_q  <= '0;
               sel_q  <= '0;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   // en and gnt come from the same flop so they can never disagree.
   assign bus.gnt  = gnt_q;
   assign bus.en   = gnt_q;
   assign bus.sel  = sel_q;
   assign bus.busy = busy_q;
endmodule

// File: tb/tb_tsb_bus_arbiter.sv
// Bench for tsb_bus_arbiter: three parameterisations driven by the same req,
// compared against a grant-level round-robin model.
module tb_tsb_bus_arbiter;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = 4'b0000;

   always #5 clk = ~clk;

   tsb_bus_arbiter_if bus0 ();
   tsb_bus_arbiter_if bus1 ();
   tsb_bus_arbiter_if bus2 ();
   assign bus0.req = req;
   assign bus1.req = req;
   assign bus2.req = req;

   tsb_bus_arbiter #(.HOLD_MAX(8), .GAP(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   tsb_bus_arbiter #(.HOLD_MAX(1), .GAP(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
   tsb_bus_arbiter #(.HOLD_MAX(8), .GAP(3)) u2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

   logic [3:0] gnt_o [3];
   logic [3:0] en_o  [3];
   logic [1:0] sel_o [3];
   logic       busy_o[3];
   assign gnt_o[0] = bus0.gnt;  assign en_o[0] = bus0.en;  assign sel_o[0] = bus0.sel;  assign busy_o[0] = bus0.busy;
   assign gnt_o[1] = bus1.gnt;  assign en_o[1] = bus1.en;  assign sel_o[1] = bus1.sel;  assign busy_o[1] = bus1.busy;
   assign gnt_o[2] = bus2.gnt;  assign en_o[2] = bus2.en;  assign sel_o[2] = bus2.sel;  assign busy_o[2] = bus2.busy;

   int checks = 0;
   int errors = 0;

   // Model: who holds the bus, for how long, how many turnaround cycles remain.
   int HM[3] = '{8, 1, 8};
   int GP[3] = '{1, 1, 3};
   int m_hold[3];
   int m_len[3];
   int m_gap[3];
   int m_ptr[3];

   function automatic int arb(input int i, input logic [3:0] r);
      for (int k = 0; k < 4; k++)
         if (r[(m_ptr[i] + k) % 4] === 1'b1) return (m_ptr[i] + k) % 4;
      return -1;
   endfunction

   function automatic logic [3:0] e_gnt(input int i);
      return (m_hold[i] >= 0) ? 4'(1 << m_hold[i]) : 4'b0000;
   endfunction

   function automatic logic [1:0] e_sel(input int i);
      return (m_hold[i] >= 0) ? 2'(m_hold[i]) : 2'd0;
   endfunction

   function automatic logic e_busy(input int i);
      return (m_hold[i] >= 0) || (m_gap[i] > 0);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_hold[i] = -1; m_len[i] = 0; m_gap[i] = 0; m_ptr[i] = 0;
      end
   endtask

   task automatic model_step(input logic [3:0] r);
      for (int i = 0; i < 3; i++) begin
         if (m_hold[i] >= 0) begin
            if (r[m_hold[i]] !== 1'b1 || m_len[i] == HM[i]) begin
               m_ptr[i]  = (m_hold[i] + 1) % 4;
               m_hold[i] = -1;
               m_gap[i]  = GP[i];
            end else begin
               m_len[i]++;
            end
         end else if (m_gap[i] > 0) begin
            m_gap[i]--;
            if (m_gap[i] == 0) begin
               m_hold[i] = arb(i, r);
               m_len[i]  = 1;
            end
         end else begin
            m_hold[i] = arb(i, r);
            m_len[i]  = 1;
         end
      end
   endtask

   task automatic step(input logic [3:0] r);
      @(negedge clk);
      req = r;
      @(posedge clk);
      if (rst_n) model_step(r);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req   = 4'b0000;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      model_reset();
      req = 4'b1111;
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (gnt_o[i] !== 4'b0000 || en_o[i] !== 4'b0000 || sel_o[i] !== 2'd0 || busy_o[i] !== 1'b0) begin
            errors++;
            $display("FAIL reset inst %0d gnt %b en %b sel %0d busy %b, want all zero", i, gnt_o[i], en_o[i], sel_o[i], busy_o[i]);
         end
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (gnt_o[0] !== 4'b0000 || busy_o[0] !== 1'b0) begin
         errors++;
         $display("FAIL reset_held gnt %b busy %b, want 0000 0", gnt_o[0], busy_o[0]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      req   = 4'b0100;
      @(posedge clk);
      model_step(req);
      #1;
      checks++;
      if (gnt_o[0] !== 4'b0100 || sel_o[0] !== 2'd2 || en_o[0] !== 4'b0100) begin
         errors++;
         $display("FAIL first_arb gnt %b en %b sel %0d, want 0100 0100 2", gnt_o[0], en_o[0], sel_o[0]);
      end
   endtask

   task automatic test_hold_release();
      int glen;
      do_reset();
      glen = 0;
      for (int c = 0; c < 24; c++) begin
         step(4'b0100);
         if (gnt_o[0] == 4'b0100 && glen >= 0) glen++;
         else if (glen > 0) begin
            checks++;
            if (glen !== 8) begin
               errors++;
               $display("FAIL hold_len got %0d cycles, want 8", glen);
            end
            glen = -1;
         end
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (gnt_o[i] !== e_gnt(i) || en_o[i] !== e_gnt(i) || sel_o[i] !== e_sel(i) || busy_o[i] !== e_busy(i)) begin
               errors++;
               $display("FAIL hold_release c%0d inst %0d gnt %b en %b sel %0d busy %b, want gnt %b sel %0d busy %b",
                        c, i, gnt_o[i], en_o[i], sel_o[i], busy_o[i], e_gnt(i), e_sel(i), e_busy(i));
            end
         end
      end
   endtask

   task automatic test_round_robin();
      int seq[$];
      logic [3:0] prev;
      do_reset();
      prev = 4'b0000;
      for (int c = 0; c < 45; c++) begin
         step(4'b1111);
         if (gnt_o[0] != 4'b0000 && prev == 4'b0000) seq.push_back(int'(sel_o[0]));
         prev = gnt_o[0];
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (gnt_o[i] !== e_gnt(i) || en_o[i] !== e_gnt(i) || sel_o[i] !== e_sel(i) || busy_o[i] !== e_busy(i)) begin
               errors++;
               $display("FAIL round_robin c%0d inst %0d gnt %b en %b sel %0d busy %b, want gnt %b sel %0d busy %b",
                        c, i, gnt_o[i], en_o[i], sel_o[i], busy_o[i], e_gnt(i), e_sel(i), e_busy(i));
            end
         end
      end
      checks++;
      if (seq.size() < 5 || seq[0] != 0 || seq[1] != 1 || seq[2] != 2 || seq[3] != 3 || seq[4] != 0) begin
         errors++;
         $display("FAIL rr_order got %p, want 0 1 2 3 0 first", seq);
      end
   endtask

   task automatic test_drop();
      do_reset();
      step(4'b0010);
      step(4'b0010);
      step(4'b0010);
      step(4'b1000);
      checks++;
      if (gnt_o[0] !== 4'b0000 || busy_o[0] !== 1'b1) begin
         errors++;
         $display("FAIL drop_turn gnt %b busy %b, want 0000 1", gnt_o[0], busy_o[0]);
      end
      step(4'b1000);
      checks++;
      if (gnt_o[0] !== 4'b1000 || sel_o[0] !== 2'd3) begin
         errors++;
         $display("FAIL drop_regrant gnt %b sel %0d, want 1000 3", gnt_o[0], sel_o[0]);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (gnt_o[i] !== e_gnt(i) || sel_o[i] !== e_sel(i) || busy_o[i] !== e_busy(i)) begin
            errors++;
            $display("FAIL drop inst %0d gnt %b sel %0d busy %b, want gnt %b sel %0d busy %b",
                     i, gnt_o[i], sel_o[i], busy_o[i], e_gnt(i), e_sel(i), e_busy(i));
         end
      end
   endtask

   task automatic test_gap3();
      int zrun;
      bit seen;
      do_reset();
      zrun = 0;
      seen = 0;
      for (int c = 0; c < 60; c++) begin
         step(4'b0101);
         if (en_o[2] == 4'b0000) zrun++;
         else begin
            if (seen && zrun > 0) begin
               checks++;
               if (zrun !== 3) begin
                  errors++;
                  $display("FAIL gap3_len got %0d idle cycles, want 3", zrun);
               end
            end
            seen = 1;
            zrun = 0;
         end
         for (int i = 0; i < 3; i++) begin
            checks++;
            if ($countones(en_o[i]) > 1 || gnt_o[i] !== e_gnt(i) || en_o[i] !== e_gnt(i) || sel_o[i] !== e_sel(i) || busy_o[i] !== e_busy(i)) begin
               errors++;
               $display("FAIL gap3 c%0d inst %0d gnt %b en %b sel %0d busy %b, want gnt %b sel %0d busy %b",
                        c, i, gnt_o[i], en_o[i], sel_o[i], busy_o[i], e_gnt(i), e_sel(i), e_busy(i));
            end
         end
      end
   endtask

   task automatic test_random();
      logic [3:0] r;
      do_reset();
      r = 4'b0000;
      for (int c = 0; c < 500; c++) begin
         if ($urandom_range(3) == 0) r = 4'($urandom_range(15));
         step(r);
         for (int i = 0; i < 3; i++) begin
            checks++;
            if ($countones(en_o[i]) > 1 || gnt_o[i] !== e_gnt(i) || en_o[i] !== e_gnt(i) || sel_o[i] !== e_sel(i) || busy_o[i] !== e_busy(i)) begin
               errors++;
               $display("FAIL random c%0d req %b inst %0d gnt %b en %b sel %0d busy %b, want gnt %b sel %0d busy %b",
                        c, r, i, gnt_o[i], en_o[i], sel_o[i], busy_o[i], e_gnt(i), e_sel(i), e_busy(i));
            end
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      step(4'b1000);
      step(4'b1000);
      checks++;
      if (gnt_o[0] !== 4'b1000) begin
         errors++;
         $display("FAIL async_pre gnt %b, want 1000", gnt_o[0]);
      end
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (gnt_o[i] !== 4'b0000 || en_o[i] !== 4'b0000 || sel_o[i] !== 2'd0 || busy_o[i] !== 1'b0) begin
            errors++;
            $display("FAIL async_reset inst %0d gnt %b en %b sel %0d busy %b, want all zero", i, gnt_o[i], en_o[i], sel_o[i], busy_o[i]);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      model_step(req);
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (gnt_o[i] !== 4'b1000 || gnt_o[i] !== e_gnt(i) || sel_o[i] !== 2'd3 || busy_o[i] !== 1'b1) begin
            errors++;
            $display("FAIL async_regrant inst %0d gnt %b sel %0d busy %b, want 1000 3 1", i, gnt_o[i], sel_o[i], busy_o[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_hold_release();
      test_round_robin();
      test_drop();
      test_gap3();
      test_random();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/tsb_bus_arbiter.md
TSB_BUS_ARBITER -- requirements
Module: tsb_bus_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 8: the maximum number of consecutive cycles one requester keeps its grant; legal range 1..255.
REQ-002 Parameter GAP, default 1: the number of turnaround cycles with all bus drivers disabled between two grants; legal range 1..15.
REQ-003 Port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port req  input  4  request from requester i, level-sensitive, held high while the requester wants the shared bus.
REQ-006 Port gnt  output  4  one-hot grant to requester i.
REQ-007 Port en  output  4  tristate-buffer enable for requester i's bus driver; en SHALL equal gnt at all times.
REQ-008 Port sel  output  2  binary index of the current grant holder, driving s1/s0 of a 4-to-1 mux; 0 when no grant.
REQ-009 Port busy  output  1  high whenever the arbiter is in GRANT or TURN.

Function
REQ-010 The arbiter SHALL implement exactly three states: IDLE, GRANT and TURN; all outputs SHALL be registered.
REQ-011 Round-robin pointer ptr (2 bits): arbitration SHALL search req[ptr], req[ptr+1], req[ptr+2], req[ptr+3] (mod 4) and pick the first one that is high.
REQ-012 IDLE: if any req bit is high at a rising edge -> GRANT on that edge; gnt, en and sel SHALL show the winner in the following cycle (1-cycle request-to-grant latency); otherwise stay in IDLE.
REQ-013 GRANT: exactly one bit of gnt SHALL be high; the hold counter SHALL be 1 in the first grant cycle and increment by 1 each cycle.
REQ-014 GRANT exit: the state SHALL move to TURN on the edge where req[holder] is sampled low, or where the hold counter equals HOLD_MAX, whichever happens first.
REQ-015 On GRANT exit, ptr SHALL become holder+1 mod 4, so a preempted requester ranks last in the next arbitration.
REQ-016 TURN: gnt=0, en=0, sel=0, busy=1 for exactly GAP cycles; after that, arbitration per REQ-011 -> GRANT if any req is high, else -> IDLE.
REQ-017 No two en bits SHALL ever be high in the same cycle, and there SHALL be at least GAP cycles of en=0 between any two grants.
REQ-018 A requester that is not the holder SHALL NOT affect gnt during GRANT; changes to its req are ignored until the next arbitration.
REQ-019 A req that pulses high for one cycle in IDLE SHALL win a full grant, which ends at the first edge where that req is sampled low.
REQ-020 With HOLD_MAX=1, every grant SHALL last exactly 1 cycle regardless of req.
REQ-021 The hold counter SHALL be ceil(log2(HOLD_MAX+1)) bits wide and SHALL never wrap.
REQ-022 req values that are X or Z SHALL be treated as not-requesting.

Reset
REQ-023 While rst_n=0: state=IDLE, ptr=0, hold counter=0, gnt=0, en=0, sel=0, busy=0; these values SHALL take effect immediately, without waiting for a clock edge.
REQ-024 When reset is asserted during GRANT, en SHALL drop asynchronously.
REQ-025 The first arbitration SHALL occur on the first rising edge after rst_n rises.

Verification
REQ-026 Release reset, req=4'b0100 held -> gnt=4'b0100, sel=2, en=4'b0100 one cycle later; forced release after 8 cycles; then 1 TURN cycle of en=0; then regrant to requester 2.
REQ-027 req=4'b1111 held, HOLD_MAX=8, GAP=1 -> grants in order 0,1,2,3,0, each 8 cycles long, separated by 1 idle-bus cycle; sel follows 0,1,2,3,0.
REQ-028 Requester 1 holds the grant and drops req after 3 cycles, while req[3] is high -> gnt=0 for 1 cycle, then gnt=4'b1000, sel=3; ptr=2 during that arbitration.
REQ-029 GAP=3, req[0] and req[2] both high -> exactly 3 cycles with en=4'b0000 between the grants; the check that at most one en bit is high passes in every cycle.
REQ-030 rst_n pulled low mid-cycle during a grant to requester 3 -> gnt, en, sel and busy all 0 before the next clk edge; after release with req=4'b1000 -> the grant returns with 1-cycle latency.
